// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier arbiter.
package mul_arb_pkg;

  localparam int XLEN = 32;  // operand width
  localparam int PLEN = 64;  // product width

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // arbitrate among requesters
    WAIT = 2'd1,  // operands held, latency counter running
    RESP = 2'd2   // product presented to the issuing requester
  } state_t;

  // Index width for n items, never less than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mul_arb_rr_picker.sv
// Combinational round-robin picker: rotate requests so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the one-hot grant back.
module mul_arb_rr_picker
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl_req;
  logic [2*NUM_REQ-1:0] dbl_gnt;
  logic [NUM_REQ-1:0]   rot_req;
  logic [NUM_REQ-1:0]   rot_gnt;
  logic [IDX_W-1:0]     rot_idx;
  logic [IDX_W:0]       idx_sum;

  // Rotate, fixed-priority pick, rotate back, and encode the winner index.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    rot_gnt = '0;
    rot_idx = '0;
    dbl_req = {req_valid, req_valid} >> rr_ptr;
    rot_req = dbl_req[NUM_REQ-1:0];
    // Descending scan so the lowest set bit overwrites last and wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        rot_gnt    = '0;
        rot_gnt[i] = 1'b1;
        rot_idx    = IDX_W'(i);
      end
    end
    dbl_gnt   = {rot_gnt, rot_gnt} << rr_ptr;
    grant     = dbl_gnt[2*NUM_REQ-1:NUM_REQ];
    idx_sum   = {1'b0, rot_idx} + {1'b0, rr_ptr};
    grant_idx = (idx_sum >= NUM_REQ_W) ? IDX_W'(idx_sum - NUM_REQ_W)
                                       : idx_sum[IDX_W-1:0];
    any       = |req_valid;
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one signed 32x32->64 multiplier among NUM_REQ
// requesters, one operation in flight at a time.
// Optional feature: define MUL_ARB_OVF_EN to add the resp_ovf output, which
// flags products outside the signed 32-bit range.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*XLEN-1:0] req_x,
  input  logic [NUM_REQ*XLEN-1:0] req_y,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [PLEN-1:0]         resp_data,
`ifdef MUL_ARB_OVF_EN
  output logic                    resp_ovf,
`endif
  output logic [XLEN-1:0]         mul_x,
  output logic [XLEN-1:0]         mul_y,
  input  logic [PLEN-1:0]         mul_s
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = idx_width(MUL_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_any;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_done;
  logic               accept;

  mul_arb_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_gnt),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  assign cnt_done = (cnt == '0);

  // Next-state logic and the grant; grants only in IDLE and never under reset.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) req_ready = pick_gnt;
        accept = !rst && pick_any;
        if (accept) state_next = WAIT;
      end
      WAIT:    if (cnt_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Response pulse decoded from the RESP state toward the issuing requester.
  always_comb begin
    resp_valid = '0;
    if (state == RESP) resp_valid[grant_q] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: operand launch, round-robin pointer, latency counter, capture.
  always_ff @(posedge clk) begin
    // NOTE: the operand and result registers are reset too, since their
    // values are visible on ports and an in-flight operation must vanish.
    if (rst) begin
      rr_ptr    <= '0;
      grant_q   <= '0;
      cnt       <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      resp_data <= '0;
`ifdef MUL_ARB_OVF_EN
      resp_ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mul_x   <= req_x[pick_idx*XLEN +: XLEN];
            mul_y   <= req_y[pick_idx*XLEN +: XLEN];
            grant_q <= pick_idx;
            rr_ptr  <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
            cnt     <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (cnt_done) begin
            resp_data <= mul_s;
`ifdef MUL_ARB_OVF_EN
            // Fits in signed 32 bits only if bits 63..31 are all equal.
            resp_ovf  <= !((&mul_s[PLEN-1:XLEN-1]) || !(|mul_s[PLEN-1:XLEN-1]));
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter with a scoreboard of expected responses.
// Exercises MUL_ARB_OVF_EN checks when that macro is defined.
module tb_mul_arbiter;

  localparam int N   = 4;
  localparam int LAT = 3;

  typedef struct {
    int          idx;
    logic [63:0] prod;
    int          cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*32-1:0] req_x = '0;
  logic [N*32-1:0] req_y = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [63:0]     resp_data;
  logic [31:0]     mul_x;
  logic [31:0]     mul_y;
  logic [63:0]     mul_s;
`ifdef MUL_ARB_OVF_EN
  logic            resp_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_arbiter #(
    .NUM_REQ     (N),
    .MUL_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
`ifdef MUL_ARB_OVF_EN
    .resp_ovf   (resp_ovf),
`endif
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_s      (mul_s)
  );

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [N-1:0] model_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return N'(1) << ((ptr + k) % N);
    end
    return '0;
  endfunction

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Multiplier stand-in with MUL_LATENCY=3: two register stages, so the
  // product is valid on mul_s by the third edge after the operands launch.
  logic [63:0] p1 = '0;
  logic [63:0] p2 = '0;
  always @(posedge clk) begin
    p1 <= smul(mul_x, mul_y);
    p2 <= p1;
  end
  assign mul_s = p2;

  // Scoreboard and reference model of the arbiter's grant behaviour.
  exp_t         sb[$];
  int           grant_log[$];
  int           grant_cyc[$];
  int           cyc     = 0;
  int           idle_at = 0;
  int           ptr_m   = 0;
  logic [N-1:0] exp_ready;
  exp_t         cur;
  int           w;

  always @(negedge clk) begin
    cyc++;
    if (resp_valid != '0) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", 64'(resp_valid), 64'd0);
      end else begin
        cur = sb.pop_front();
        check("resp_dest", 64'(resp_valid), 64'(N'(1) << cur.idx));
        check("resp_data", resp_data, cur.prod);
        check("resp_latency", 64'(cyc - cur.cyc), 64'(LAT + 1));
`ifdef MUL_ARB_OVF_EN
        check("resp_ovf", 64'(resp_ovf),
              64'(($signed(cur.prod) > 64'sd2147483647) ||
                  ($signed(cur.prod) < -64'sd2147483648)));
`endif
      end
    end
    exp_ready = '0;
    if (!rst && cyc >= idle_at) exp_ready = model_pick(req_valid, ptr_m);
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (rst) begin
      sb.delete();
      ptr_m   = 0;
      idle_at = cyc + 1;
    end else if ((req_valid & exp_ready) != '0) begin
      w        = oh2idx(exp_ready);
      cur.idx  = w;
      cur.prod = smul(req_x[32*w +: 32], req_y[32*w +: 32]);
      cur.cyc  = cyc;
      sb.push_back(cur);
      grant_log.push_back(w);
      grant_cyc.push_back(cyc);
      ptr_m   = (w + 1) % N;
      idle_at = cyc + LAT + 2;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y);
    req_x[32*i +: 32] = x;
    req_y[32*i +: 32] = y;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom);
  endtask

  // Raise mask, wait for a handshake, drop all requests after the accept edge.
  task automatic issue(input logic [N-1:0] mask, output int idx);
    bit got;
    got = 0;
    idx = -1;
    req_valid = mask;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      #1;
      if ((req_valid & req_ready) != '0) begin
        got = 1;
        idx = oh2idx(req_ready);
      end
    end
    check("issue_timeout", 64'(got), 64'd1);
    step();
    req_valid = '0;
  endtask

  task automatic wait_resp();
    bit seen;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (resp_valid != '0) seen = 1;
    end
    check("resp_timeout", 64'(seen), 64'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 60 && !(sb.size() == 0 && cyc >= idle_at)) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", 64'(k < 60), 64'd1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int idx;
    int mark;
    int cnt_all;
    int cnt_r2;

    // Reset with every requester asking.
    rst       = 1'b1;
    req_valid = '1;
    rand_ops();
    step();
    step();
    @(negedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("first_grant", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    drain();

    // Single operation from requester 1: -3 * 7.
    set_op(1, 32'hFFFF_FFFD, 32'd7);
    issue(4'b0010, idx);
    check("single_grant", 64'(idx), 64'd1);
    wait_resp();
    check("single_dest", 64'(resp_valid), 64'h2);
    check("single_data", resp_data, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    #1;
    check("single_pulse", 64'(resp_valid), 64'd0);
    drain();

    // Fairness: all valid for 25 cycles from a fresh pointer.
    rst = 1'b1;
    step();
    rst  = 1'b0;
    mark = grant_log.size();
    req_valid = '1;
    for (int c = 0; c < 25; c++) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    drain();
    check("fair_count", 64'(grant_log.size() - mark), 64'd5);
    for (int k = 0; k < 5 && mark + k < grant_log.size(); k++) begin
      check("fair_order", 64'(grant_log[mark+k]), 64'(k % N));
      if (k > 0) check("fair_spacing", 64'(grant_cyc[mark+k] - grant_cyc[mark+k-1]), 64'(LAT + 2));
    end

    // Overflow boundaries.
    set_op(0, 32'h8000_0000, 32'h8000_0000);
    issue(4'b0001, idx);
    wait_resp();
    check("ovf_min_data", resp_data, 64'h4000_0000_0000_0000);
`ifdef MUL_ARB_OVF_EN
    check("ovf_min_flag", 64'(resp_ovf), 64'd1);
`endif
    drain();
    set_op(0, 32'h7FFF_FFFF, 32'd1);
    issue(4'b0001, idx);
    wait_resp();
    check("ovf_max_data", resp_data, 64'h0000_0000_7FFF_FFFF);
`ifdef MUL_ARB_OVF_EN
    check("ovf_max_flag", 64'(resp_ovf), 64'd0);
`endif
    drain();

    // Reset in the middle of an operation; pointer was left at 2 by req1.
    set_op(1, 32'd1234, 32'd5678);
    issue(4'b0010, idx);
    check("midrst_grant", 64'(idx), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      check("midrst_no_resp", 64'(resp_valid), 64'd0);
    end
    step();
    rand_ops();
    req_valid = '1;
    @(negedge clk);
    #1;
    check("midrst_next_grant", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    drain();

    // Withdrawal: req2 asks only while req0's operation is in flight.
    mark = grant_log.size();
    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_op(2, 32'd9, 32'd9);
    issue(4'b0001, idx);
    req_valid = 4'b0100;
    step();
    step();
    req_valid = '0;
    drain();
    cnt_all = grant_log.size() - mark;
    cnt_r2  = 0;
    for (int k = mark; k < grant_log.size(); k++) if (grant_log[k] == 2) cnt_r2++;
    check("withdraw_grants", 64'(cnt_all), 64'd1);
    check("withdraw_req2", 64'(cnt_r2), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
